// File: rtl/fp32_div_if.sv
// Operand/result handshake bundle for the iterative fp32 divider.
// valid_in/ready_out: an operand pair transfers on a rising edge where both are high; valid_out is a one-cycle result pulse.
interface fp32_div_if;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        valid_out;
    logic [31:0] c_out;

    modport master (
        output valid_in, a_in, b_in,
        input  ready_out, valid_out, c_out
    );

    modport slave (
        input  valid_in, a_in, b_in,
        output ready_out, valid_out, c_out
    );
endinterface

// File: rtl/fp32_div.sv
// Iterative fp32 divider: radix-2 restoring mantissa division, round to nearest even,
// denormals flushed to zero, fixed 29-cycle latency from accept edge to result edge.
module fp32_div (
    input  logic        clk_in,
    input  logic        rst_in,
    fp32_div_if.slave   bus,
    output logic [2:0]  state_dbg
);
    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

    state_t             state;
    logic [31:0]        a_r, b_r;
    logic               sign, a_zero, a_inf, b_zero, b_inf;
    logic signed [9:0]  e;
    logic [23:0]        mb;
    logic [24:0]        rem;
    logic [25:0]        q;
    logic [4:0]         cnt;
    logic [31:0]        res;
    logic               valid_q;
    logic [31:0]        c_q;

    logic               qbit;
    logic [24:0]        rem_step;
    logic [24:0]        rem_next;
    logic [23:0]        m_pre;
    logic               guard, sticky;
    logic [24:0]        m_inc;
    logic [23:0]        m_fin;
    logic signed [9:0]  e_adj, e_fin;
    logic [31:0]        res_next;

    assign bus.ready_out = (state == IDLE) && !rst_in;
    assign bus.valid_out = valid_q;
    assign bus.c_out     = c_q;
    assign state_dbg     = state;

    // rem stays below 2*mb, so after a conditional subtract it fits in 24 bits and the shift never overflows.
    always_comb begin
        qbit     = (rem >= {1'b0, mb});
        rem_step = qbit ? (rem - {1'b0, mb}) : rem;
        rem_next = {rem_step[23:0], 1'b0};
    end

    always_comb begin
        if (q[25]) begin
            m_pre  = q[25:2];
            guard  = q[1];
            sticky = q[0] | (rem != 25'd0);
            e_adj  = e;
        end else begin
            m_pre  = q[24:1];
            guard  = q[0];
            sticky = (rem != 25'd0);
            e_adj  = e - 10'sd1;
        end
        m_inc = {1'b0, m_pre} + {24'd0, guard && (sticky || m_pre[0])};
        if (m_inc[24]) begin
            m_fin = 24'h800000;
            e_fin = e_adj + 10'sd1;
        end else begin
            m_fin = m_inc[23:0];
            e_fin = e_adj;
        end

        if ((a_zero && b_zero) || (a_inf && b_inf))
            res_next = 32'h7FC00000;
        else if (a_inf || (b_zero && !a_zero))
            res_next = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_inf)
            res_next = {sign, 31'd0};
        else if (e_fin >= 10'sd255)
            res_next = {sign, 8'hFF, 23'd0};
        else if (e_fin <= 10'sd0)
            res_next = {sign, 31'd0};
        else
            res_next = {sign, e_fin[7:0], m_fin[22:0]};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            sign    <= 1'b0;
            a_zero  <= 1'b0;
            a_inf   <= 1'b0;
            b_zero  <= 1'b0;
            b_inf   <= 1'b0;
            e       <= 10'sd0;
            mb      <= 24'd0;
            rem     <= 25'd0;
            q       <= 26'd0;
            cnt     <= 5'd0;
            res     <= 32'd0;
            valid_q <= 1'b0;
            c_q     <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        a_r   <= bus.a_in;
                        b_r   <= bus.b_in;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign   <= a_r[31] ^ b_r[31];
                    a_zero <= (a_r[30:23] == 8'd0);
                    a_inf  <= (a_r[30:23] == 8'hFF);
                    b_zero <= (b_r[30:23] == 8'd0);
                    b_inf  <= (b_r[30:23] == 8'hFF);
                    e      <= 10'({2'b00, a_r[30:23]}) - 10'({2'b00, b_r[30:23]}) + 10'd127;
                    mb     <= {1'b1, b_r[22:0]};
                    rem    <= {2'b01, a_r[22:0]};
                    q      <= 26'd0;
                    cnt    <= 5'd0;
                    state  <= DIVIDE;
                end
                DIVIDE: begin
                    rem <= rem_next;
                    q   <= {q[24:0], qbit};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd25)
                        state <= ROUND;
                end
                ROUND: begin
                    res   <= res_next;
                    state <= DONE;
                end
                DONE: begin
                    c_q     <= res;
                    valid_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_div.sv
// Bench for fp32_div: directed spec vectors, randomized operands against an exact
// integer-division reference, held-valid throughput and mid-operation reset.
module tb_fp32_div;
    logic       clk_in;
    logic       rst_in;
    logic [2:0] state_dbg;

    fp32_div_if bus ();

    fp32_div dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int          total = 0;
    int          bad = 0;
    int          n_pulse = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact reference: long quotient by integer division, then round-to-nearest-even on the true value.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, ex, sh;
        logic az, ai, bz, bi;
        longint unsigned na, nb, quo, rmd, mant, low, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0); ai = (ea == 255);
        bz = (eb == 0); bi = (eb == 255);
        if ((az && bz) || (ai && bi)) return 32'h7FC00000;
        if (ai || (bz && !az)) return {s, 8'hFF, 23'd0};
        if (az || bi) return {s, 31'd0};
        na  = 64'({1'b1, a[22:0]});
        nb  = 64'({1'b1, b[22:0]});
        quo = (na << 30) / nb;
        rmd = (na << 30) % nb;
        ex  = ea - eb + 127;
        if (quo >= (64'd1 << 30)) sh = 7;
        else begin sh = 6; ex = ex - 1; end
        mant = quo >> sh;
        low  = quo & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (low > half || (low == half && (rmd != 0 || mant[0]))) mant = mant + 64'd1;
        if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; ex = ex + 1; end
        if (ex >= 255) return {s, 8'hFF, 23'd0};
        if (ex <= 0) return {s, 31'd0};
        return {s, 8'(ex), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int r;
        logic [7:0] ex;
        r = $urandom_range(0, 15);
        if (r == 0) ex = 8'd0;
        else if (r == 1) ex = 8'hFF;
        else if (r == 2) ex = 8'($urandom_range(0, 255));
        else ex = 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), ex, 23'($urandom())};
    endfunction

    // scoreboard
    always @(negedge clk_in) begin
        if (bus.valid_out) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(bus.valid_out), 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
                check("c_out", bus.c_out, last_exp);
            end
        end
    end

    // driver tasks
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!bus.ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!bus.ready_out) check("ready_wait", 32'(bus.ready_out), 32'd1);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int lat;
        logic ready_bad;
        exp_q.push_back(exp);
        send(a, b);
        lat = 0;
        ready_bad = bus.ready_out;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in);
            #1;
            if (bus.valid_out) begin
                lat = k;
                break;
            end
            if (bus.ready_out) ready_bad = 1'b1;
        end
        check("latency", 32'(lat), 32'd29);
        check("ready_busy", 32'(ready_bad), 32'd0);
        @(posedge clk_in);
        #1;
        check("pulse_width", 32'(bus.valid_out), 32'd0);
        @(negedge clk_in);
    endtask

    logic [31:0] dir_a [12] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                32'h00000000, 32'hBF800000, 32'h7F800000, 32'h7F000000,
                                32'h00800000, 32'h00400000, 32'hC1200000, 32'h40490FDB};
    logic [31:0] dir_b [12] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
                                32'h00000000, 32'h7F800000, 32'h7F800000, 32'h3E800000,
                                32'h40000000, 32'h3F800000, 32'h40A00000, 32'h3F800000};
    logic [31:0] dir_c [12] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'h7F800000,
                                32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'h7F800000,
                                32'h00000000, 32'h00000000, 32'hC0000000, 32'h40490FDB};

    initial begin
        int n_acc, p0;
        logic [31:0] ra, rb;
        rst_in       = 1'b1;
        bus.valid_in = 1'b0;
        bus.a_in     = 32'd0;
        bus.b_in     = 32'd0;
        repeat (3) @(negedge clk_in);
        check("rst_ready", 32'(bus.ready_out), 32'd0);
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_c_out", bus.c_out, 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_in = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.ready_out), 32'd1);
        @(negedge clk_in);

        for (int i = 0; i < 12; i++) run_op(dir_a[i], dir_b[i], dir_c[i]);

        for (int i = 0; i < 40; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            run_op(ra, rb, ref_div(ra, rb));
        end

        // valid_in held high with fresh operands every cycle
        n_acc = 0;
        p0 = n_pulse;
        for (int i = 0; i < 65; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom())};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom())};
            bus.a_in     = ra;
            bus.b_in     = rb;
            bus.valid_in = 1'b1;
            if (bus.ready_out) begin
                exp_q.push_back(ref_div(ra, rb));
                n_acc++;
            end
            @(negedge clk_in);
        end
        bus.valid_in = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk_in);
        check("held_accepts", 32'(n_acc), 32'd3);
        check("held_pulses", 32'(n_pulse - p0), 32'(n_acc));
        repeat (5) @(negedge clk_in);
        check("c_hold", bus.c_out, last_exp);

        // reset during DIVIDE iteration 10
        send(32'h40400000, 32'h3F800000);
        repeat (11) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        check("abort_valid", 32'(bus.valid_out), 32'd0);
        check("abort_c_out", bus.c_out, 32'd0);
        check("abort_ready", 32'(bus.ready_out), 32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("ready_after_abort", 32'(bus.ready_out), 32'd1);
        p0 = n_pulse;
        repeat (40) @(negedge clk_in);
        check("abort_no_pulse", 32'(n_pulse - p0), 32'd0);
        run_op(32'h41200000, 32'h40A00000, 32'h40000000);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp32_div.md
Name: fp32_div

Overview:
Iterative IEEE-754 single-precision divider, c = a / b, using a radix-2 restoring mantissa divider.
- Serves the same pipeline datapath as the fp32 multiplier; used where division is rare, e.g. perspective divide and reciprocal setup.
- One operation in flight; valid/ready input handshake; fixed latency.
- Denormal inputs are treated as zero and denormal results are flushed to zero, matching the multiplier's conventions.

Parameters:
None. Latency is fixed at 29 cycles; the format is fixed at fp32.

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  asynchronous, active-high reset
valid_in  input  1  operands valid; accepted on a rising edge where valid_in && ready_out
ready_out  output  1  high only in IDLE when rst_in is low; divider can accept
a_in  input  32  dividend, fp32
b_in  input  32  divisor, fp32
valid_out  output  1  one-cycle pulse, c_out valid
c_out  output  32  quotient, fp32; holds the last result until the next valid_out

Behaviour:
- Reset (asynchronous) forces state IDLE, valid_out=0 and c_out=0. ready_out=0 while rst_in is high, and 1 in the first cycle after release.
- States: IDLE -> UNPACK (1 cycle) -> DIVIDE (26 cycles) -> ROUND (1 cycle) -> DONE (1 cycle, valid_out=1) -> IDLE.
- Timing: the accept edge is edge 0. valid_out is high in the cycle after edge 29. ready_out is 0 from edge 0 through DONE, so throughput is 1 op per 30 cycles.
- valid_in while busy is ignored; no queueing, operands are not latched.
- UNPACK:
  - sign = a[31]^b[31].
  - Exponent field 0 means the operand is zero; 255 means inf (NaN inputs are treated as inf).
  - Mantissa ma/mb = {1, frac}, 24 bits.
  - e = ea - eb + 127, signed 10-bit.
- DIVIDE: rem initialised to ma, 25 bits. Each cycle:
  - if rem >= mb: qbit=1 and rem -= mb; otherwise qbit=0;
  - q = {q, qbit}; rem <<= 1.
  - After 26 iterations, q[25:0] holds the quotient, with the integer bit at q[25].
- ROUND:
  - If q[25]=1: m = q[25:2], guard = q[1], sticky = q[0] | (rem != 0).
  - Else: m = q[24:1], guard = q[0], sticky = (rem != 0), e = e - 1.
  - Round to nearest even: increment m if guard && (sticky || m[0]).
  - If the increment carries out, m = 1.0 and e = e + 1.
- Result selection, in priority order; the result is registered into c_out in DONE:
  - 0/0 or inf/inf -> 0x7FC00000 (sign 0).
  - a inf, or b zero (a nonzero) -> {sign, 0xFF, 0}.
  - a zero, or b inf -> {sign, 0x00, 0}.
  - e >= 255 -> {sign, 0xFF, 0}.
  - e <= 0 -> {sign, 0x00, 0}. Flush; the fraction is cleared, not retained.
  - Otherwise {sign, e[7:0], m[22:0]}.
- Special cases still take the full 29-cycle latency, so latency never depends on data.
- Reset mid-operation: the operation is abandoned and no valid_out pulse occurs for it, either during or after reset.
- Edge case: ready_out drops on edge 0, so a valid_in held high is accepted exactly once per operation.

Test Plan:
1. 0x40C00000 / 0x40000000 (6/2), single accept -> valid_out 29 cycles later with c_out=0x40400000. valid_out is high for exactly 1 cycle, and ready_out is 0 for cycles 1..29.
2. 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, exercising the round-up path. Also 0x3F800000 / 0x3F800000 -> 0x3F800000 (exact, q[25]=1 path).
3. Special cases, with latency still 29:
   - 0x3F800000 / 0x00000000 -> 0x7F800000
   - 0x00000000 / 0x00000000 -> 0x7FC00000
   - 0xBF800000 / 0x7F800000 -> 0x80000000
   - 0x7F800000 / 0x7F800000 -> 0x7FC00000
4. Range limits:
   - 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow)
   - 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush)
   - 0x00400000 (denormal) / 0x3F800000 -> 0x00000000
5. valid_in held high with a new operand each cycle:
   - Only operands present at accept edges are divided, one per 30 cycles.
   - Operands presented while busy produce no output.
   - c_out holds between pulses.
6. Assert rst_in at DIVIDE iteration 10 for 2 cycles:
   - valid_out=0 and c_out=0 immediately (asynchronously).
   - No pulse occurs for the aborted op.
   - ready_out=1 after release.
   - A subsequent 0x41200000 / 0x40A00000 -> 0x40000000 after 29 cycles.
